pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_entry.sv | 37 +++
 rtl/pipe_stage_elastic.sv | 115 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the elastic pipeline stage registers
package pipe_pkg;

    localparam int CTRL_W_DEF         = 3;

    // Bit positions inside the default control bundle
    localparam int CTRL_REGWRITE      = 0;
    localparam int CTRL_RESULTSRC_LSB = 1;
    localparam int CTRL_MEMWRITE      = 2;

    // Datapath bundle widths of the four stage registers
    localparam int IF_ID_W            = 64;   // instr, pc
    localparam int ID_EX_W            = 133;  // rs1, rs2, pc, imm, rd
    localparam int EX_MEM_W           = 101;  // alu result, store data, pc+4, rd
    localparam int MEM_WB_W           = 101;  // alu result, load data, pc+4, rd

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+ctrl+data holding register with load/clear controls
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_valid,
    input  logic              zero_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Load wins over clear; the caller gates load when a flush must win.
    // Clearing leaves data untouched so only the ctrl bits toggle on bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end else begin
            if (clr_valid) valid <= 1'b0;
            if (zero_ctrl) ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage register with skid buffer and flush
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        count
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              ready_q;
    logic              accept, emit;
    logic              load_main, load_skid, main_from_skid;
    logic              clr_main, clr_skid;
    logic              main_nv, skid_nv;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

    // With a skid buffer in_ready is a flop (no out_ready path); without it
    // the single register may refill in the cycle it drains.
    assign in_ready = (SKID != 0) ? (rst & ready_q)
                                  : (rst & (~main_valid | out_ready));
    assign accept   = in_valid & in_ready;
    assign emit     = main_valid & out_ready;

    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            if ((SKID != 0) && skid_valid) begin
                if (emit) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end else if (accept) begin
                if (!main_valid || emit) begin
                    load_main = 1'b1;
                end else if (SKID != 0) begin
                    load_skid = 1'b1;
                end
            end
        end
    end

    assign clr_main    = flush | (emit & ~load_main);
    assign clr_skid    = flush | main_from_skid;
    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    assign main_nv = load_main | (main_valid & ~clr_main);
    assign skid_nv = load_skid | (skid_valid & ~clr_skid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b1;
            count   <= 2'd0;
        end else begin
            ready_q <= ~skid_nv;
            count   <= {1'b0, main_nv} + {1'b0, skid_nv};
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (load_main),
        .clr_valid (clr_main),
        .zero_ctrl (clr_main),
        .d_data    (main_d_data),
        .d_ctrl    (main_d_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (load_skid),
        .clr_valid (clr_skid),
        .zero_ctrl (clr_skid),
        .d_data    (in_data),
        .d_ctrl    (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - table vectors plus queue scoreboard for both SKID variants
module tb_pipe_stage_elastic;

    localparam int DW = 32;
    localparam int CW = 3;

    typedef logic [DW+CW-1:0] beat_t;

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic [1:0]    en;
        logic          er;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, flush;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]    count1, count0;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    bit    e_rdy0, e_rdy1;
    beat_t q0[$];
    beat_t q1[$];
    beat_t hd;
    vec_t  vt[18];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
        .flush(flush), .count(count1)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .flush(flush), .count(count0)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a FIFO of accepted beats per DUT; the head must be on out_*.
    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy1 = rst && (q1.size() < 2);
            e_rdy0 = rst && (q0.size() == 0 || out_ready);
            cmp("sb1.in_ready", in_ready1, e_rdy1);
            cmp("sb1.out_valid", out_valid1, q1.size() > 0);
            cmp("sb1.count", count1, q1.size());
            if (q1.size() > 0) begin
                hd = q1[0];
                cmp("sb1.out_data", out_data1, hd[DW-1:0]);
                cmp("sb1.out_ctrl", out_ctrl1, hd[DW+CW-1:DW]);
            end else begin
                cmp("sb1.bubble_ctrl", out_ctrl1, 0);
            end
            cmp("sb0.in_ready", in_ready0, e_rdy0);
            cmp("sb0.out_valid", out_valid0, q0.size() > 0);
            cmp("sb0.count", count0, q0.size());
            if (q0.size() > 0) begin
                hd = q0[0];
                cmp("sb0.out_data", out_data0, hd[DW-1:0]);
                cmp("sb0.out_ctrl", out_ctrl0, hd[DW+CW-1:DW]);
            end else begin
                cmp("sb0.bubble_ctrl", out_ctrl0, 0);
            end
            if (!rst || flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() > 0 && out_ready) void'(q1.pop_front());
                if (in_valid && e_rdy1) q1.push_back({in_ctrl, in_data});
                if (q0.size() > 0 && out_ready) void'(q0.pop_front());
                if (in_valid && e_rdy0) q0.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        #7 chk_en = 1'b1;
    end

    initial begin
        // rst iv data ctrl ordy flush | SKID=1 after edge: valid data ctrl count in_ready
        vt[0]  = '{1'b0, 1'b1, 32'h99, 3'd7, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h99, 3'd7, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 32'h11, 3'd1, 1'b1, 1'b0, 1'b1, 32'h11, 3'd1, 2'd1, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 32'h22, 3'd2, 1'b1, 1'b0, 1'b1, 32'h22, 3'd2, 2'd1, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 32'h33, 3'd3, 1'b1, 1'b0, 1'b1, 32'h33, 3'd3, 2'd1, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 32'hA1, 3'd5, 1'b0, 1'b0, 1'b1, 32'hA1, 3'd5, 2'd1, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 32'hA2, 3'd6, 1'b0, 1'b0, 1'b1, 32'hA1, 3'd5, 2'd2, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b0, 1'b0, 1'b1, 32'hA1, 3'd5, 2'd2, 1'b0};
        vt[10] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b1, 32'hA2, 3'd6, 2'd1, 1'b1};
        vt[11] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[12] = '{1'b1, 1'b1, 32'hB1, 3'd5, 1'b0, 1'b0, 1'b1, 32'hB1, 3'd5, 2'd1, 1'b1};
        vt[13] = '{1'b1, 1'b1, 32'hB2, 3'd5, 1'b0, 1'b0, 1'b1, 32'hB1, 3'd5, 2'd2, 1'b0};
        vt[14] = '{1'b1, 1'b1, 32'hFF, 3'd7, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[15] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[16] = '{1'b1, 1'b1, 32'hC1, 3'd3, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};
        vt[17] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 2'd0, 1'b1};

        for (int i = 0; i < 18; i++) begin
            rst       = vt[i].rst;
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            in_ctrl   = vt[i].c;
            out_ready = vt[i].ordy;
            flush     = vt[i].fl;
            @(posedge clk);
            #1;
            cmp($sformatf("vec%0d.out_valid", i), out_valid1, vt[i].ev);
            cmp($sformatf("vec%0d.out_ctrl", i), out_ctrl1, vt[i].ec);
            cmp($sformatf("vec%0d.count", i), count1, vt[i].en);
            cmp($sformatf("vec%0d.in_ready", i), in_ready1, vt[i].er);
            if (vt[i].ev) cmp($sformatf("vec%0d.out_data", i), out_data1, vt[i].ed);
        end

        // SKID=0: accept and emit in the same cycle
        in_valid  = 1'b1;
        in_data   = 32'h4;
        in_ctrl   = 3'd1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_data = 32'h5;
        in_ctrl = 3'd2;
        @(negedge clk);
        cmp("same.in_ready0", in_ready0, 1);
        cmp("same.out_valid0", out_valid0, 1);
        @(posedge clk);
        #1;
        cmp("same.out_data0", out_data0, 32'h5);
        cmp("same.count0", count0, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset while stalled with two beats held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD1;
        in_ctrl   = 3'd5;
        @(posedge clk);
        #1;
        in_data = 32'hD2;
        in_ctrl = 3'd6;
        @(posedge clk);
        #1;
        cmp("stall.count1", count1, 2);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        cmp("rstmid.out_valid1", out_valid1, 0);
        cmp("rstmid.count1", count1, 0);
        cmp("rstmid.out_data1", out_data1, 0);
        cmp("rstmid.out_ctrl1", out_ctrl1, 0);
        cmp("rstmid.out_valid0", out_valid0, 0);
        cmp("rstmid.out_data0", out_data0, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("rstmid.reappear%0d", k), out_valid1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
